// File: rtl/lsu_issue_queue.sv
// In-order LSU issue queue: buffers load/store uOPs, snoops writeback broadcasts for
// operand readiness and releases only the head entry to the LSU once it is fully ready.
module lsu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int UOP_W  = 96,
  parameter int PREG_W = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_enq_valid,
  output logic                       o_enq_ready,
  input  logic [UOP_W-1:0]           i_enq_uop,
  input  logic [PREG_W-1:0]          i_enq_rs0,
  input  logic                       i_enq_rs0_rdy,
  input  logic [PREG_W-1:0]          i_enq_rs1,
  input  logic                       i_enq_rs1_rdy,
  input  logic                       i_wk0_valid,
  input  logic [PREG_W-1:0]          i_wk0_preg,
  input  logic                       i_wk1_valid,
  input  logic [PREG_W-1:0]          i_wk1_preg,
  input  logic                       i_wk2_valid,
  input  logic [PREG_W-1:0]          i_wk2_preg,
  input  logic                       i_lsu_busy,
  output logic                       o_iss_valid,
  output logic [UOP_W-1:0]           o_iss_uop,
  output logic [PREG_W-1:0]          o_iss_rs0,
  output logic [PREG_W-1:0]          o_iss_rs1,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [UOP_W-1:0]  r_uop [DEPTH];
  logic [PREG_W-1:0] r_rs0 [DEPTH];
  logic [PREG_W-1:0] r_rs1 [DEPTH];
  logic [DEPTH-1:0]  r_rdy0;
  logic [DEPTH-1:0]  r_rdy1;

  logic             w_empty;
  logic             w_full;
  logic             w_enq_fire;
  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;

  function automatic logic wakeHit(input logic [PREG_W-1:0] p);
    wakeHit = (i_wk0_valid && (i_wk0_preg == p)) ||
              (i_wk1_valid && (i_wk1_preg == p)) ||
              (i_wk2_valid && (i_wk2_preg == p));
  endfunction

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

  // Ready depends on pointers only, so a full queue refuses even while the head pops.
  assign o_enq_ready = ~w_full;
  assign w_enq_fire  = i_enq_valid & ~w_full & ~i_flush;

  assign o_iss_valid = ~w_empty & r_rdy0[w_head_idx] & r_rdy1[w_head_idx] & ~i_lsu_busy & ~i_flush;
  assign o_iss_uop   = r_uop[w_head_idx];
  assign o_iss_rs0   = r_rs0[w_head_idx];
  assign o_iss_rs1   = r_rs1[w_head_idx];
  assign o_count     = r_tail - r_head;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_enq_fire)  r_tail <= r_tail + PTR_W'(1);
      if (o_iss_valid) r_head <= r_head + PTR_W'(1);
    end
  end

  // Stale slots may get woken too; harmless since occupancy comes from the pointers.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wakeHit(r_rs0[i])) r_rdy0[i] <= 1'b1;
      if (wakeHit(r_rs1[i])) r_rdy1[i] <= 1'b1;
    end
    if (w_enq_fire) begin
      r_uop[w_tail_idx]  <= i_enq_uop;
      r_rs0[w_tail_idx]  <= i_enq_rs0;
      r_rs1[w_tail_idx]  <= i_enq_rs1;
      r_rdy0[w_tail_idx] <= i_enq_rs0_rdy | wakeHit(i_enq_rs0);
      r_rdy1[w_tail_idx] <= i_enq_rs1_rdy | wakeHit(i_enq_rs1);
    end
  end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Bench for lsu_issue_queue: per-cycle vector table plus fill/drain, flush and reset
// sequences; issued payloads are checked against a scoreboard of accepted uOPs.
module tb_lsu_issue_queue;

  localparam int DEPTH  = 8;
  localparam int UOP_W  = 96;
  localparam int PREG_W = 6;

  typedef struct {
    logic              rst;
    logic              flush;
    logic              busy;
    logic              enqValid;
    logic [UOP_W-1:0]  uop;
    logic [PREG_W-1:0] rs0;
    logic              rs0Rdy;
    logic [PREG_W-1:0] rs1;
    logic              rs1Rdy;
    logic              wk0v;
    logic [PREG_W-1:0] wk0p;
    logic              wk1v;
    logic [PREG_W-1:0] wk1p;
    logic              wk2v;
    logic [PREG_W-1:0] wk2p;
    logic              expIss;
    int                expCount;
    logic              expReady;
  } row_t;

  typedef struct {
    logic [UOP_W-1:0]  uop;
    logic [PREG_W-1:0] rs0;
    logic [PREG_W-1:0] rs1;
  } sbEntry_t;

  logic              clk = 1'b0;
  logic              rst, flush, enqValid, rs0Rdy, rs1Rdy;
  logic              wk0v, wk1v, wk2v, busy;
  logic [UOP_W-1:0]  enqUop;
  logic [PREG_W-1:0] rs0, rs1, wk0p, wk1p, wk2p;
  logic              enqReady, issValid;
  logic [UOP_W-1:0]  issUop;
  logic [PREG_W-1:0] issRs0, issRs1;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  sbEntry_t sb[$];
  row_t vec[27];
  row_t r;

  always #5 clk = ~clk;

  lsu_issue_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W), .PREG_W(PREG_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_enq_valid(enqValid), .o_enq_ready(enqReady), .i_enq_uop(enqUop),
    .i_enq_rs0(rs0), .i_enq_rs0_rdy(rs0Rdy), .i_enq_rs1(rs1), .i_enq_rs1_rdy(rs1Rdy),
    .i_wk0_valid(wk0v), .i_wk0_preg(wk0p), .i_wk1_valid(wk1v), .i_wk1_preg(wk1p),
    .i_wk2_valid(wk2v), .i_wk2_preg(wk2p), .i_lsu_busy(busy),
    .o_iss_valid(issValid), .o_iss_uop(issUop), .o_iss_rs0(issRs0), .o_iss_rs1(issRs1),
    .o_count(count)
  );

  function automatic row_t idleRow(input logic expIss, input int expCount);
    row_t t;
    t.rst = 0; t.flush = 0; t.busy = 0; t.enqValid = 0; t.uop = '0;
    t.rs0 = '0; t.rs0Rdy = 1; t.rs1 = '0; t.rs1Rdy = 1;
    t.wk0v = 0; t.wk0p = '0; t.wk1v = 0; t.wk1p = '0; t.wk2v = 0; t.wk2p = '0;
    t.expIss = expIss; t.expCount = expCount; t.expReady = (expCount < DEPTH);
    return t;
  endfunction

  function automatic row_t enqRow(input int id, input logic [PREG_W-1:0] a, input logic aRdy,
                                  input logic [PREG_W-1:0] b, input logic bRdy,
                                  input logic expIss, input int expCount);
    row_t t;
    t = idleRow(expIss, expCount);
    t.enqValid = 1; t.uop = UOP_W'(id) | {8'hA5, 88'h0};
    t.rs0 = a; t.rs0Rdy = aRdy; t.rs1 = b; t.rs1Rdy = bRdy;
    return t;
  endfunction

  task automatic cmpVal(input string name, input logic [UOP_W-1:0] act, input logic [UOP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input row_t t, input string name);
    sbEntry_t e;
    cmpVal({name, "_iss"}, UOP_W'(issValid), UOP_W'(t.expIss));
    cmpVal({name, "_count"}, UOP_W'(count), UOP_W'(t.expCount));
    cmpVal({name, "_ready"}, UOP_W'(enqReady), UOP_W'(t.expReady));
    if (issValid === 1'b1 && !t.rst) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s_sb actual=issue required=no_issue", name);
      end else begin
        e = sb.pop_front();
        cmpVal({name, "_uop"}, issUop, e.uop);
        cmpVal({name, "_rs0"}, UOP_W'(issRs0), UOP_W'(e.rs0));
        cmpVal({name, "_rs1"}, UOP_W'(issRs1), UOP_W'(e.rs1));
      end
    end
  endtask

  task automatic applyStimulus(input row_t t, input string name);
    sbEntry_t e;
    @(negedge clk);
    rst = t.rst; flush = t.flush; busy = t.busy; enqValid = t.enqValid; enqUop = t.uop;
    rs0 = t.rs0; rs0Rdy = t.rs0Rdy; rs1 = t.rs1; rs1Rdy = t.rs1Rdy;
    wk0v = t.wk0v; wk0p = t.wk0p; wk1v = t.wk1v; wk1p = t.wk1p; wk2v = t.wk2v; wk2p = t.wk2p;
    #1;
    checkOutput(t, name);
    if (t.enqValid && t.expReady && !t.flush && !t.rst) begin
      e.uop = t.uop; e.rs0 = t.rs0; e.rs1 = t.rs1;
      sb.push_back(e);
    end
  endtask

  initial begin
    rst = 1; flush = 0; busy = 0; enqValid = 0; enqUop = '0;
    rs0 = '0; rs0Rdy = 0; rs1 = '0; rs1Rdy = 0;
    wk0v = 0; wk0p = '0; wk1v = 0; wk1p = '0; wk2v = 0; wk2p = '0;
    repeat (2) @(posedge clk);

    vec[0]  = idleRow(0, 0);
    vec[1]  = enqRow(1, 6'd1, 1, 6'd2, 1, 0, 0);
    vec[2]  = idleRow(1, 1);
    vec[3]  = idleRow(0, 0);
    vec[4]  = enqRow(2, 6'd5, 0, 6'd6, 1, 0, 0);
    vec[5]  = idleRow(0, 1); vec[5].wk1v = 1; vec[5].wk1p = 6'd5;
    vec[6]  = idleRow(1, 1);
    vec[7]  = idleRow(0, 0);
    vec[8]  = enqRow(3, 6'd7, 0, 6'd8, 1, 0, 0); vec[8].wk0v = 1; vec[8].wk0p = 6'd7;
    vec[9]  = idleRow(1, 1);
    vec[10] = idleRow(0, 0);
    vec[11] = enqRow(4, 6'd9, 0, 6'd10, 1, 0, 0);
    vec[12] = enqRow(5, 6'd11, 1, 6'd12, 1, 0, 1);
    vec[13] = idleRow(0, 2); vec[13].wk0v = 1; vec[13].wk0p = 6'd20;
    vec[14] = idleRow(0, 2); vec[14].wk2v = 1; vec[14].wk2p = 6'd9;
    vec[15] = idleRow(1, 2);
    vec[16] = idleRow(1, 1);
    vec[17] = idleRow(0, 0);
    vec[18] = enqRow(6, 6'd13, 1, 6'd14, 0, 0, 0);
    vec[19] = idleRow(0, 1); vec[19].busy = 1; vec[19].wk0v = 1; vec[19].wk0p = 6'd14;
    vec[20] = idleRow(0, 1); vec[20].busy = 1;
    vec[21] = idleRow(1, 1);
    vec[22] = idleRow(0, 0);
    vec[23] = enqRow(7, 6'd15, 1, 6'd16, 1, 0, 0);
    vec[24] = enqRow(8, 6'd17, 1, 6'd18, 1, 1, 1);
    vec[25] = idleRow(1, 1);
    vec[26] = idleRow(0, 0);

    for (int i = 0; i < 27; i++) applyStimulus(vec[i], $sformatf("vec%0d", i));

    // Fill under busy, refuse the ninth, then drain across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      r = enqRow(100 + i, PREG_W'(i), 1, PREG_W'(i + 8), 1, 0, i);
      r.busy = 1;
      applyStimulus(r, $sformatf("fill%0d", i));
    end
    r = enqRow(200, 6'd30, 1, 6'd31, 1, 0, DEPTH); r.busy = 1;
    applyStimulus(r, "refuse9");
    for (int i = 0; i < DEPTH; i++) applyStimulus(idleRow(1, DEPTH - i), $sformatf("drain%0d", i));
    applyStimulus(idleRow(0, 0), "drained");

    // Flush with a concurrent enqueue at count 5.
    for (int i = 0; i < 5; i++) begin
      r = enqRow(300 + i, 6'd40, 1, 6'd41, 1, 0, i); r.busy = 1;
      applyStimulus(r, $sformatf("pre_flush%0d", i));
    end
    r = enqRow(399, 6'd42, 1, 6'd43, 1, 0, 5); r.flush = 1;
    applyStimulus(r, "flush_cycle");
    sb.delete();
    applyStimulus(idleRow(0, 0), "post_flush");
    applyStimulus(enqRow(400, 6'd44, 1, 6'd45, 1, 0, 0), "flush_enq");
    applyStimulus(idleRow(1, 1), "flush_iss");
    applyStimulus(idleRow(0, 0), "flush_done");

    // Reset mid-stream with a concurrent enqueue.
    for (int i = 0; i < 3; i++) begin
      r = enqRow(500 + i, 6'd50, 1, 6'd51, 1, 0, i); r.busy = 1;
      applyStimulus(r, $sformatf("pre_rst%0d", i));
    end
    r = enqRow(599, 6'd52, 1, 6'd53, 1, 0, 3); r.rst = 1; r.busy = 1;
    applyStimulus(r, "rst_cycle");
    sb.delete();
    applyStimulus(idleRow(0, 0), "post_rst");
    applyStimulus(enqRow(600, 6'd54, 1, 6'd55, 1, 0, 0), "rst_enq");
    applyStimulus(idleRow(1, 1), "rst_iss");
    applyStimulus(idleRow(0, 0), "rst_done");

    cmpVal("sb_empty", UOP_W'(sb.size()), UOP_W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
